// File: rtl/avm_write_master.sv
// avm_write_master: Avalon-MM write master fed from an internal user FIFO; optional macro AVM_WRITE_PARTIAL_EN
module avm_write_master #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                control_fixed_location,
  input  logic [ADDR_W-1:0]   control_write_base,
  input  logic [LEN_W-1:0]    control_write_length,
  input  logic                control_go,
  output logic                control_done,
  output logic                control_busy,
  input  logic                user_write_buffer,
  input  logic [DATA_W-1:0]   user_buffer_data,
  output logic                user_buffer_full,
  output logic [ADDR_W-1:0]   master_address,
  output logic                master_write,
  output logic [DATA_W-1:0]   master_writedata,
  output logic [DATA_W/8-1:0] master_byteenable,
  input  logic                master_waitrequest
);
  localparam int BYTES = DATA_W / 8;
  localparam int LG = $clog2(BYTES);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic fixed_q, fixed_d;
  logic [LEN_W-1:0] rem_q, rem_d, words;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic full_q, full_d, push, pop, empty;
`ifdef AVM_WRITE_PARTIAL_EN
  logic [BYTES-1:0] last_be_q, last_be_d, go_be;
  logic [LEN_W-1:0] low;
  always_comb begin
    low = control_write_length & LEN_W'(BYTES - 1);
    words = (control_write_length >> LG) + LEN_W'(low != '0);
    for (int i = 0; i < BYTES; i++) go_be[i] = (low == '0) || (LEN_W'(i) < low);
    last_be_d = (state_q == IDLE && control_go) ? go_be : last_be_q;
  end
  always_ff @(posedge clk)
    if (rst) last_be_q <= '1;
    else last_be_q <= last_be_d;
  assign master_byteenable = (rem_q == LEN_W'(1)) ? last_be_q : '1;
`else
  assign words = control_write_length >> LG;
  assign master_byteenable = '1;
`endif
  assign empty            = count_q == '0;
  assign master_write     = state_q == RUN && !empty && rem_q != '0;
  assign pop              = master_write && !master_waitrequest;
  // a full FIFO drops the push even when a pop frees a slot this cycle
  assign push             = user_write_buffer && !full_q;
  assign master_writedata = empty ? '0 : mem_q[rd_ptr_q];
  assign master_address   = addr_q;
  assign control_done     = state_q == DONE;
  assign control_busy     = state_q != IDLE;
  assign user_buffer_full = full_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    full_d   = count_d == (PW+1)'(FIFO_DEPTH);
    fixed_d  = fixed_q;
    addr_d   = (pop && !fixed_q) ? addr_q + ADDR_W'(BYTES) : addr_q;
    rem_d    = rem_q - LEN_W'(pop);
    state_d  = state_q;
    case (state_q)
      IDLE: if (control_go) begin
        state_d = RUN;
        addr_d  = control_write_base;
        fixed_d = control_fixed_location;
        rem_d   = words;
      end
      RUN:     state_d = (rem_d == '0) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      fixed_q  <= 1'b0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fixed_q  <= fixed_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= user_buffer_data;
endmodule

// File: tb/tb_avm_write_master.sv
// tb_avm_write_master: randomized and directed check of avm_write_master against a queue-based model
module tb_avm_write_master;
  logic clk = 0, rst = 1;
  logic control_fixed_location = 0, control_go = 0, control_done, control_busy;
  logic [31:0] control_write_base = 0, control_write_length = 0;
  logic user_write_buffer = 0, user_buffer_full;
  logic [31:0] user_buffer_data = 0, master_address, master_writedata;
  logic master_write, master_waitrequest = 0;
  logic [3:0] master_byteenable;
  int n_chk = 0, n_fail = 0, dut_acc = 0, base_acc;
  bit checking = 0;
  logic [31:0] mq[$];
  int m_state = 0, m_rem = 0, m_len = 0;
  logic [31:0] m_addr = 0, prev_addr, prev_data;
  bit m_fixed = 0, prev_stall = 0;

  avm_write_master dut (
    .clk(clk), .rst(rst),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go), .control_done(control_done), .control_busy(control_busy),
    .user_write_buffer(user_write_buffer), .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full),
    .master_address(master_address), .master_write(master_write),
    .master_writedata(master_writedata), .master_byteenable(master_byteenable),
    .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int words_of(input int len);
`ifdef AVM_WRITE_PARTIAL_EN
    return (len + 3) / 4;
`else
    return len / 4;
`endif
  endfunction

  function automatic logic [3:0] exp_be();
`ifdef AVM_WRITE_PARTIAL_EN
    if (m_rem == 1 && m_len % 4 != 0) return 4'((1 << (m_len % 4)) - 1);
`endif
    return 4'hF;
  endfunction

  always @(negedge clk) begin
    bit exp_write, was_full;
    exp_write = m_state == 1 && mq.size() != 0 && m_rem != 0;
    if (checking) begin
      check("done", control_done, m_state == 2);
      check("busy", control_busy, m_state != 0);
      check("full", user_buffer_full, mq.size() == 16);
      check("write", master_write, exp_write);
      if (prev_stall && master_write) begin
        check("stall_addr", master_address, prev_addr);
        check("stall_data", master_writedata, prev_data);
      end
      if (master_write && exp_write) begin
        check("addr", master_address, m_addr);
        check("data", master_writedata, mq[0]);
        check("be", master_byteenable, exp_be());
      end
    end
    if (!rst && master_write && !master_waitrequest) dut_acc++;
    prev_stall = !rst && master_write && master_waitrequest;
    prev_addr = master_address;
    prev_data = master_writedata;
    if (rst) begin
      mq.delete();
      m_state = 0;
      m_rem = 0;
    end else begin
      was_full = mq.size() == 16;
      if (exp_write && !master_waitrequest) begin
        void'(mq.pop_front());
        m_rem--;
        if (!m_fixed) m_addr += 4;
      end
      if (user_write_buffer && !was_full) mq.push_back(user_buffer_data);
      case (m_state)
        0: if (control_go) begin
          m_state = 1;
          m_addr = control_write_base;
          m_fixed = control_fixed_location;
          m_len = int'(control_write_length);
          m_rem = words_of(m_len);
        end
        1: if (m_rem == 0) m_state = 2;
        default: m_state = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    control_go = 0;
    user_write_buffer = 0;
  endtask

  task automatic push_word(input logic [31:0] d);
    user_write_buffer = 1;
    user_buffer_data = d;
    step();
  endtask

  task automatic go_xfer(input logic [31:0] base, input logic [31:0] len, input bit fixed);
    control_go = 1;
    control_write_base = base;
    control_write_length = len;
    control_fixed_location = fixed;
    step();
  endtask

  initial begin
    repeat (2) step();
    rst = 0;
    checking = 1;
    @(negedge clk);
    check("rst_addr", master_address, 0);
    check("rst_data", master_writedata, 0);
    check("rst_be", master_byteenable, 4'hF);
    check("rst_write", master_write, 0);
    step();
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
    base_acc = dut_acc;
    go_xfer(32'h100, 16, 0);
    repeat (8) step();
    check("t1_acc", dut_acc - base_acc, 4);
    for (int i = 0; i < 4; i++) push_word(32'hB0 + i);
    base_acc = dut_acc;
    go_xfer(32'h100, 16, 1);
    step();
    master_waitrequest = 1;
    repeat (3) step();
    master_waitrequest = 0;
    repeat (8) step();
    check("t2_acc", dut_acc - base_acc, 4);
    for (int i = 0; i < 17; i++) push_word(32'h200 + i);
    check("t3_full", user_buffer_full, 1);
    base_acc = dut_acc;
    go_xfer(32'h0, 64, 0);
    repeat (24) step();
    check("t3_acc", dut_acc - base_acc, 16);
    base_acc = dut_acc;
    go_xfer(32'h80, 0, 0);
    repeat (4) step();
    check("t4_acc", dut_acc - base_acc, 0);
    for (int i = 0; i < 2; i++) push_word(32'hC0 + i);
    base_acc = dut_acc;
    go_xfer(32'h40, 6, 0);
    repeat (6) step();
`ifdef AVM_WRITE_PARTIAL_EN
    check("t5_acc", dut_acc - base_acc, 2);
`else
    check("t5_acc", dut_acc - base_acc, 1);
`endif
    for (int i = 0; i < 4; i++) push_word(32'hD0 + i);
    go_xfer(32'h300, 16, 0);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    check("t6_busy", control_busy, 0);
    check("t6_full", user_buffer_full, 0);
    for (int i = 0; i < 2; i++) push_word(32'hE0 + i);
    base_acc = dut_acc;
    go_xfer(32'h500, 8, 0);
    repeat (6) step();
    check("t6_acc", dut_acc - base_acc, 2);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 499) == 0;
      user_write_buffer = $urandom_range(0, 1) == 1;
      user_buffer_data = $urandom;
      master_waitrequest = $urandom_range(0, 3) == 0;
      control_go = $urandom_range(0, 7) == 0;
      control_write_base = $urandom & 32'hFFFC;
      control_write_length = $urandom_range(0, 40);
      control_fixed_location = $urandom_range(0, 3) == 0;
      @(posedge clk);
      #1;
    end
    rst = 0;
    control_go = 0;
    user_write_buffer = 0;
    master_waitrequest = 0;
    repeat (60) step();
    check("final_idle", control_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
